gpr_dump_ctrl: RTL and testbench
================================

GPR_DUMP_CTRL -- requirements
Module: gpr_dump_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the number of GPRs dumped (legal range 2..32).
REQ-002 The block SHALL have port clk_i, input, 1 bit: clock.
REQ-003 The block SHALL have port rst_ni, input, 1 bit: reset, asynchronous, active-low.
REQ-004 The block SHALL have port start_i, input, 1 bit: dump request pulse (e.g. core halted).
REQ-005 The block SHALL have port busy_o, output, 1 bit: dump in progress.
REQ-006 The block SHALL have port done_o, output, 1 bit: one-cycle pulse when the dump completes.
REQ-007 The block SHALL have port core_rd_req_i, input, 1 bit: the core is using the GPR read port this cycle.
REQ-008 The block SHALL have port core_raddr_i, input, 5 bits: core read address.
REQ-009 The block SHALL have port rf_raddr_o, output, 5 bits: address to the shared GPR read port.
REQ-010 The block SHALL have port rf_rdata_i, input, 32 bits: read data, valid one cycle after the address.
REQ-011 The block SHALL have ports dump_valid_o (output, 1 bit) and dump_ready_i (input, 1 bit): output stream handshake.
REQ-012 The block SHALL have ports dump_idx_o (output, 5 bits) and dump_data_o (output, 32 bits): register index and value.
REQ-013 The block SHALL have ports test_pass_o and test_fail_o, outputs, 1 bit each: latched test verdict.

Function
REQ-014 rf_raddr_o SHALL equal core_raddr_i whenever core_rd_req_i=1 (core has absolute priority), else the dump pointer ptr.
REQ-015 FSM states SHALL be IDLE, READ, WAIT, OUT; busy_o=1 in every state except IDLE.
REQ-016 IDLE: start_i=1 -> ptr=0, clear test_pass_o/test_fail_o, go to READ; start_i while busy SHALL be ignored.
REQ-017 READ: core_rd_req_i=0 -> read issued at ptr, go to WAIT; core_rd_req_i=1 -> stay in READ (stall, no read issued).
REQ-018 WAIT: capture rf_rdata_i into the output buffer with dump_idx_o=ptr, assert dump_valid_o next cycle, go to OUT; core_rd_req_i in WAIT SHALL NOT corrupt the capture.
REQ-019 OUT: dump_valid_o=1, dump_idx_o/dump_data_o held stable until dump_ready_i=1.
REQ-020 OUT with dump_ready_i=1 and ptr<NUM_REGS-1 -> ptr+1, go to READ; with ptr==NUM_REGS-1 -> done_o=1 for exactly one cycle, go to IDLE.
REQ-021 Minimum dump time SHALL be 3*NUM_REGS cycles with no stall and dump_ready_i tied high.
REQ-022 dump_valid_o SHALL be 0 in IDLE, READ and WAIT.

Reset
REQ-023 While rst_ni=0 the block SHALL hold IDLE, ptr=0, busy_o=0, done_o=0, dump_valid_o=0, dump_idx_o=0, dump_data_o=0, test_pass_o=0, test_fail_o=0.
REQ-024 Reset asserted mid-dump SHALL abort immediately with no done_o pulse; the next dump starts from index 0.

Configuration
REQ-025 Macro GPR_DUMP_RESULT_CHECK_EN defined: captured values of x26 and x27 SHALL be stored; at the done_o cycle, test_pass_o<=(x26==1 && x27==1) and test_fail_o<=(x26==1 && x27!=1); both remain 0 if x26!=1 or NUM_REGS<28; the verdict is held until the next accepted start_i.
REQ-026 Macro GPR_DUMP_RESULT_CHECK_EN undefined: test_pass_o and test_fail_o SHALL be constant 0 and no x26/x27 storage SHALL exist.

Verification
REQ-027 Regfile x[i]=i*0x10, ready=1, no core requests, start pulse -> 32 beats idx 0..31 with data 0x000..0x1F0, done_o at cycle 96, busy_o low afterwards.
REQ-028 core_rd_req_i=1 for 5 cycles during READ at ptr=7 -> rf_raddr_o follows core_raddr_i, no beat emitted while stalled, beat idx 7 carries correct data, total time +5 cycles.
REQ-029 dump_ready_i low for 4 cycles at idx 3 -> dump_valid_o stays 1 with idx/data stable, no beat lost or duplicated.
REQ-030 With macro: x26=1,x27=1 -> test_pass_o=1 at done; x26=1,x27=0 -> test_fail_o=1; x26=0 -> both 0; without macro -> both 0 in all three cases.
REQ-031 rst_ni pulsed low at idx 12, then start -> busy_o=0 and dump_valid_o=0 during reset, no done_o pulse, new dump begins at idx 0.
REQ-032 start_i pulsed at idx 5 during a dump -> ignored, exactly one done_o, 32 beats total.

Source files
------------

// File: rtl/gpr_dump_ctrl.sv
// Streams the GPR file out over a valid/ready channel through the shared read port.
// Optional: define GPR_DUMP_RESULT_CHECK_EN to derive a pass/fail verdict from x26/x27.
module gpr_dump_ctrl #(
    parameter int unsigned NUM_REGS = 32
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        start_i,
    output logic        busy_o,
    output logic        done_o,
    input  logic        core_rd_req_i,
    input  logic [4:0]  core_raddr_i,
    output logic [4:0]  rf_raddr_o,
    input  logic [31:0] rf_rdata_i,
    output logic        dump_valid_o,
    input  logic        dump_ready_i,
    output logic [4:0]  dump_idx_o,
    output logic [31:0] dump_data_o,
    output logic        test_pass_o,
    output logic        test_fail_o
);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        WAIT,
        OUT
    } state_e;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_e      state_q, state_d;
    logic [4:0]  ptr_q;
    logic        start_ok;
    logic        capture;
    logic        advance;
    logic        finish;

    // The core always wins the shared port; the dump simply waits in READ.
    assign rf_raddr_o = core_rd_req_i ? core_raddr_i : ptr_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        dump_valid_o = 1'b0;
        start_ok     = 1'b0;
        capture      = 1'b0;
        advance      = 1'b0;
        finish       = 1'b0;
        unique case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    start_ok = 1'b1;
                    state_d  = READ;
                end
            end
            READ: begin
                if (!core_rd_req_i) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Data for the address issued in READ arrives now, whatever the core drives.
                capture = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                dump_valid_o = 1'b1;
                if (dump_ready_i) begin
                    if (ptr_q == LAST_IDX) begin
                        finish  = 1'b1;
                        done_o  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        advance = 1'b1;
                        state_d = READ;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q <= '0;
        end else if (start_ok || finish) begin
            ptr_q <= '0;
        end else if (advance) begin
            ptr_q <= ptr_q + 5'd1;
        end
    end

    // NOTE: the output buffer is reset explicitly because its value is visible on the ports in IDLE.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dump_idx_o  <= '0;
            dump_data_o <= '0;
        end else if (capture) begin
            dump_idx_o  <= ptr_q;
            dump_data_o <= rf_rdata_i;
        end
    end

`ifdef GPR_DUMP_RESULT_CHECK_EN
    generate
        if (NUM_REGS >= 28) begin : g_result_check
            logic [31:0] x26_q;
            logic [31:0] x27_q;
            logic        pass_q;
            logic        fail_q;

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    x26_q <= '0;
                    x27_q <= '0;
                end else if (capture) begin
                    if (ptr_q == 5'd26) x26_q <= rf_rdata_i;
                    if (ptr_q == 5'd27) x27_q <= rf_rdata_i;
                end
            end

            // Verdict is cleared by an accepted start and held after done until the next one.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    pass_q <= 1'b0;
                    fail_q <= 1'b0;
                end else if (start_ok) begin
                    pass_q <= 1'b0;
                    fail_q <= 1'b0;
                end else if (finish) begin
                    pass_q <= (x26_q == 32'd1) && (x27_q == 32'd1);
                    fail_q <= (x26_q == 32'd1) && (x27_q != 32'd1);
                end
            end

            assign test_pass_o = pass_q;
            assign test_fail_o = fail_q;
        end else begin : g_no_result_check
            assign test_pass_o = 1'b0;
            assign test_fail_o = 1'b0;
        end
    endgenerate
`else
    assign test_pass_o = 1'b0;
    assign test_fail_o = 1'b0;
`endif

endmodule

// File: tb/tb_gpr_dump_ctrl.sv
// Self-checking bench for gpr_dump_ctrl: directed timing cases plus randomized dumps
// scored against a register-array reference of the expected beat sequence.
module tb_gpr_dump_ctrl;

    localparam int N = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        start_main;
    logic        start_extra;
    logic        busy;
    logic        done;
    logic        core_req;
    logic [4:0]  core_raddr;
    logic [4:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        valid;
    logic        ready;
    logic [4:0]  idx;
    logic [31:0] data;
    logic        test_pass;
    logic        test_fail;

    logic [31:0] regs [N];

    int checks = 0;
    int errors = 0;

    // stimulus controls
    bit rand_mode      = 1'b0;
    int core_stall_idx = -1;
    int core_stall_len = 0;
    bit core_trig      = 1'b0;
    int core_left      = 0;
    int ready_idx      = -1;
    bit ready_used     = 1'b0;
    int ready_left     = 0;
    int start_idx      = -1;
    bit start_used     = 1'b0;

    // scoreboard state
    int          exp_idx    = 0;
    int          beats      = 0;
    int          dones      = 0;
    bit          prev_stall = 1'b0;
    logic [4:0]  prev_idx;
    logic [31:0] prev_data;

    always #5 clk = ~clk;

    assign start = start_main | start_extra;

    gpr_dump_ctrl #(.NUM_REGS(N)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .start_i      (start),
        .busy_o       (busy),
        .done_o       (done),
        .core_rd_req_i(core_req),
        .core_raddr_i (core_raddr),
        .rf_raddr_o   (rf_raddr),
        .rf_rdata_i   (rf_rdata),
        .dump_valid_o (valid),
        .dump_ready_i (ready),
        .dump_idx_o   (idx),
        .dump_data_o  (data),
        .test_pass_o  (test_pass),
        .test_fail_o  (test_fail)
    );

    // Register file with one cycle of read latency.
    always @(posedge clk) rf_rdata <= regs[rf_raddr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Input driver, one update just after every rising edge.
    always @(posedge clk) begin
        #1;
        start_extra = 1'b0;
        core_raddr  = 5'($urandom);
        if (rand_mode) begin
            core_req = ($urandom_range(0, 3) == 0);
            ready    = ($urandom_range(0, 2) != 0);
            // Only in READ/WAIT, so the next edge is guaranteed to still be mid-dump.
            if (busy && !valid && $urandom_range(0, 15) == 0) start_extra = 1'b1;
        end else begin
            if (core_trig) begin
                core_left = core_stall_len;
                core_trig = 1'b0;
            end
            if (core_left > 0) begin
                core_req = 1'b1;
                core_left--;
            end else begin
                core_req = 1'b0;
            end
            if (ready_idx >= 0 && !ready_used && valid && idx == 5'(ready_idx)) begin
                ready_left = 4;
                ready_used = 1'b1;
            end
            if (ready_left > 0) begin
                ready = 1'b0;
                ready_left--;
            end else begin
                ready = 1'b1;
            end
            if (start_idx >= 0 && !start_used && valid && idx == 5'(start_idx)) begin
                start_extra = 1'b1;
                start_used  = 1'b1;
            end
        end
    end

    // Monitor: beats must arrive in index order with the register contents, stay stable
    // while back-pressured, and done must coincide with acceptance of the last beat.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_busy", busy, 0);
            check("rst_valid", valid, 0);
            check("rst_done", done, 0);
            exp_idx    = 0;
            prev_stall = 1'b0;
        end else begin
            if (core_req) check("raddr_core", rf_raddr, core_raddr);
            if (!rand_mode && core_req) check("no_beat_in_stall", valid, 0);
            if (prev_stall) begin
                check("stall_valid", valid, 1);
                check("stall_idx", idx, prev_idx);
                check("stall_data", data, prev_data);
            end
            check("done", done, valid && ready && (idx == 5'(N - 1)));
            if (valid) begin
                check("busy_in_out", busy, 1);
                check("beat_idx", idx, 32'(exp_idx));
                check("beat_data", data, regs[exp_idx % N]);
                if (ready) begin
                    beats++;
                    if (exp_idx == core_stall_idx) core_trig = 1'b1;
                    exp_idx++;
                end
            end
            if (done) begin
                dones++;
                exp_idx = 0;
            end
            prev_stall = valid && !ready;
            prev_idx   = idx;
            prev_data  = data;
        end
    end

    // Runs one dump from a start pulse; cyc counts edges from start acceptance to done.
    task automatic run_dump(output int cyc);
        beats      = 0;
        dones      = 0;
        start_main = 1'b1;
        @(posedge clk);
        #1;
        start_main = 1'b0;
        cyc        = 1;
        check("busy_after_start", busy, 1);
        check("verdict_cleared", {test_pass, test_fail}, 0);
        while (1) begin
            @(negedge clk);
            #1;
            if (dones != 0 || cyc >= 4000) break;
            @(posedge clk);
            cyc++;
        end
        check("dump_finished", dones != 0, 1);
        @(posedge clk);
        #1;
        check("busy_after_done", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        check("beat_count", beats, N);
        check("done_count", dones, 1);
    endtask

    task automatic check_verdict();
        logic exp_pass;
        logic exp_fail;
`ifdef GPR_DUMP_RESULT_CHECK_EN
        exp_pass = (regs[26] == 32'd1) && (regs[27] == 32'd1);
        exp_fail = (regs[26] == 32'd1) && (regs[27] != 32'd1);
`else
        exp_pass = 1'b0;
        exp_fail = 1'b0;
`endif
        check("test_pass", test_pass, exp_pass);
        check("test_fail", test_fail, exp_fail);
    endtask

    initial begin
        int cyc;
        int k;
        rst_n       = 1'b0;
        start_main  = 1'b0;
        start_extra = 1'b0;
        core_req    = 1'b0;
        core_raddr  = '0;
        ready       = 1'b1;
        for (int i = 0; i < N; i++) regs[i] = 32'(i * 16);

        repeat (3) @(posedge clk);
        #1;
        check("rst_idx", idx, 0);
        check("rst_data", data, 0);
        check("rst_pass", test_pass, 0);
        check("rst_fail", test_fail, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Unstalled dump of x[i] = i*0x10.
        run_dump(cyc);
        check("time_nominal", cyc, 3 * N);
        check_verdict();

        // Core holds the read port for 5 cycles while the dump waits to read x7.
        core_stall_idx = 6;
        core_stall_len = 5;
        run_dump(cyc);
        check("time_core_stall", cyc, 3 * N + 5);
        core_stall_idx = -1;

        // Consumer back-pressure for 4 cycles on beat 3.
        ready_idx  = 3;
        ready_used = 1'b0;
        run_dump(cyc);
        check("time_ready_stall", cyc, 3 * N + 4);
        ready_idx = -1;

        // Verdict cases: pass, fail, no verdict.
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < N; i++) regs[i] = $urandom;
            regs[26] = (c < 2) ? 32'd1 : 32'd0;
            regs[27] = (c == 0) ? 32'd1 : 32'd0;
            run_dump(cyc);
            check_verdict();
            repeat (5) @(posedge clk);
            #1;
            check_verdict();
        end

        // Reset in the middle of a dump, then a clean dump from index 0.
        for (int i = 0; i < N; i++) regs[i] = $urandom;
        beats      = 0;
        dones      = 0;
        start_main = 1'b1;
        @(posedge clk);
        #1;
        start_main = 1'b0;
        k = 0;
        while (!(valid && idx == 5'd12) && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("reached_idx12", k < 1000, 1);
        #1;
        rst_n = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("abort_idx", idx, 0);
            check("abort_data", data, 0);
        end
        check("abort_no_done", dones, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_dump(cyc);
        check("time_after_abort", cyc, 3 * N);

        // Start request mid-dump must be ignored.
        start_idx  = 5;
        start_used = 1'b0;
        run_dump(cyc);
        check("time_ignored_start", cyc, 3 * N);
        check("extra_start_issued", start_used, 1);
        start_idx = -1;

        // Randomized back-pressure, core contention and spurious starts.
        rand_mode = 1'b1;
        for (int d = 0; d < 6; d++) begin
            for (int i = 0; i < N; i++) regs[i] = $urandom;
            if (d == 0) begin
                regs[26] = 32'd1;
                regs[27] = 32'd1;
            end
            run_dump(cyc);
            check_verdict();
        end
        rand_mode = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
